// File: rtl/rc4_stream_core_if.sv
`default_nettype none
// ============================================================================
// Module      : rc4_stream_core_if
// Description : Key-load, control and valid/ready streaming bundle for the
//               self-sequencing RC4 core.
// Revision    : 1.0 - initial release
// ============================================================================
interface rc4_stream_core_if #(
    parameter int W          = 4,
    parameter int KEYLEN_MAX = 16,
    parameter int KLW        = $clog2(KEYLEN_MAX + 1),
    parameter int KAW        = (KEYLEN_MAX > 1) ? $clog2(KEYLEN_MAX) : 1
);
    logic           key_wr;
    logic [KAW-1:0] key_addr;
    logic [W-1:0]   key_din;
    logic [KLW-1:0] key_len;
    logic           start;
    logic           busy;
    logic           ready;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_ready;

    // Core side
    modport slave (
        input  key_wr, key_addr, key_din, key_len, start,
        input  in_valid, in_data, out_ready,
        output busy, ready, in_ready, out_valid, out_data
    );

    // Host / stream side
    modport master (
        output key_wr, key_addr, key_din, key_len, start,
        output in_valid, in_data, out_ready,
        input  busy, ready, in_ready, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/rc4_stream_core.sv
`default_nettype none
// ============================================================================
// Module      : rc4_stream_core
// Description : Self-sequencing RC4 engine. Internal FSM runs S-box init,
//               key scheduling, then XORs a valid/ready word stream with the
//               generated keystream (1 word/cycle, 1-cycle latency).
// Revision    : 1.0 - initial release
// ============================================================================
module rc4_stream_core #(
    parameter int W          = 4,
    parameter int KEYLEN_MAX = 16,
    parameter int KLW        = $clog2(KEYLEN_MAX + 1)
) (
    input  logic              clk,
    input  logic              reset,
    rc4_stream_core_if.slave  bus
);
    localparam int KAW = (KEYLEN_MAX > 1) ? $clog2(KEYLEN_MAX) : 1;
    localparam int c_depth = 1 << W;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_init = 2'd1;
    localparam logic [1:0] c_st_ksa  = 2'd2;
    localparam logic [1:0] c_st_prga = 2'd3;

    localparam logic [W-1:0]   c_last   = {W{1'b1}};
    localparam logic [W-1:0]   c_one_w  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [KLW-1:0] c_lenmax = KLW'(KEYLEN_MAX);
    localparam logic [KLW-1:0] c_one_l  = {{(KLW-1){1'b0}}, 1'b1};
    localparam logic [KAW:0]   c_keymax = (KAW+1)'(KEYLEN_MAX);
    localparam logic [KAW-1:0] c_one_k  = {{(KAW-1){1'b0}}, 1'b1};

    logic [1:0]     r_state;
    logic [W-1:0]   r_i;
    logic [W-1:0]   r_j;
    logic [KAW-1:0] r_kidx;
    logic [KLW-1:0] r_len;
    logic [W-1:0]   r_sbox [c_depth];
    logic [W-1:0]   r_key  [KEYLEN_MAX];
    logic           r_out_valid;
    logic [W-1:0]   r_out_data;

    logic           w_start_ok;
    logic [KLW-1:0] w_len_sel;
    logic           w_key_wr_ok;
    logic           w_klast;
    logic [W-1:0]   w_ksa_si, w_ksa_j, w_ksa_sj;
    logic [W-1:0]   w_pi, w_si, w_pj, w_sj, w_t, w_st, w_ks;
    logic           w_in_ready;
    logic           w_consume;

    // Control qualifiers: start only honoured in IDLE/PRGA, key writes likewise
    assign w_start_ok  = bus.start && (r_state == c_st_idle || r_state == c_st_prga);
    assign w_len_sel   = (bus.key_len == '0 || bus.key_len > c_lenmax) ? c_lenmax : bus.key_len;
    assign w_key_wr_ok = bus.key_wr && (r_state == c_st_idle || r_state == c_st_prga)
                         && ({1'b0, bus.key_addr} < c_keymax);

    // KSA datapath; the key index is its own wrapping counter (no modulo)
    assign w_klast  = (KLW'(r_kidx) == (r_len - c_one_l));
    assign w_ksa_si = r_sbox[r_i];
    assign w_ksa_j  = r_j + w_ksa_si + r_key[r_kidx];
    assign w_ksa_sj = r_sbox[w_ksa_j];

    // PRGA datapath; keystream lookup must see the post-swap S-box, so the
    // two swapped locations are forwarded instead of reading the array
    assign w_pi = r_i + c_one_w;
    assign w_si = r_sbox[w_pi];
    assign w_pj = r_j + w_si;
    assign w_sj = r_sbox[w_pj];
    assign w_t  = w_si + w_sj;
    assign w_st = r_sbox[w_t];
    assign w_ks = (w_t == w_pi) ? w_sj : ((w_t == w_pj) ? w_si : w_st);

    assign w_in_ready = (r_state == c_st_prga) && (!r_out_valid || bus.out_ready);
    assign w_consume  = w_in_ready && bus.in_valid;

    // Sequencer: IDLE -> INIT (2^W) -> KSA (2^W) -> PRGA, start in PRGA re-keys
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_i     <= '0;
            r_j     <= '0;
            r_kidx  <= '0;
            r_len   <= '0;
        end else begin
            case (r_state)
                c_st_idle, c_st_prga: begin
                    if (w_start_ok) begin
                        r_state <= c_st_init;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_kidx  <= '0;
                        r_len   <= w_len_sel;
                    end else if (w_consume) begin
                        r_i <= w_pi;
                        r_j <= w_pj;
                    end
                end
                c_st_init: begin
                    r_i <= r_i + c_one_w;
                    if (r_i == c_last) begin
                        r_state <= c_st_ksa;
                        r_j     <= '0;
                        r_kidx  <= '0;
                    end
                end
                c_st_ksa: begin
                    r_i    <= r_i + c_one_w;
                    r_j    <= w_ksa_j;
                    r_kidx <= w_klast ? '0 : (r_kidx + c_one_k);
                    if (r_i == c_last) begin
                        r_state <= c_st_prga;
                        r_j     <= '0;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // S-box: identity fill in INIT, single-edge swaps in KSA and on each PRGA word
    always_ff @(posedge clk) begin
        if (!reset) begin
            case (r_state)
                c_st_init: r_sbox[r_i] <= r_i;
                c_st_ksa: begin
                    r_sbox[r_i]     <= w_ksa_sj;
                    r_sbox[w_ksa_j] <= w_ksa_si;
                end
                c_st_prga: begin
                    if (w_consume) begin
                        r_sbox[w_pi] <= w_sj;
                        r_sbox[w_pj] <= w_si;
                    end
                end
                default: ;
            endcase
        end
    end

    // Key register file, writable only while the schedule is not running
    always_ff @(posedge clk) begin
        if (!reset && w_key_wr_ok) begin
            r_key[bus.key_addr] <= bus.key_din;
        end
    end

    // Output stage: holds a word until accepted, reset drops any pending word
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_consume) begin
            r_out_valid <= 1'b1;
            r_out_data  <= bus.in_data ^ w_ks;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.busy      = (r_state == c_st_init) || (r_state == c_st_ksa);
    assign bus.ready     = (r_state == c_st_prga);
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
endmodule
`default_nettype wire

// File: tb/tb_rc4_stream_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_rc4_stream_core
// Description : Directed self-checking bench for rc4_stream_core. Three cores
//               (W=8/KEYLEN_MAX=16, W=8/KEYLEN_MAX=3, W=4/KEYLEN_MAX=16) share
//               one stimulus bus; sel picks the active core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rc4_stream_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_g = 1'b1;
    logic       rst_one = 1'b0;
    int         sel = 0;
    logic       key_wr = 1'b0;
    logic [3:0] key_addr = '0;
    logic [7:0] key_din = '0;
    logic [4:0] key_len = '0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       out_ready = 1'b1;

    logic       busy_m, ready_m, in_ready_m, out_valid_m;
    logic [7:0] out_data_m;
    logic       rst_a, rst_b, rst_c;

    int total = 0;
    int bad = 0;

    assign rst_a = rst_g | (rst_one & (sel == 0));
    assign rst_b = rst_g | (rst_one & (sel == 1));
    assign rst_c = rst_g | (rst_one & (sel == 2));

    rc4_stream_core_if #(.W(8), .KEYLEN_MAX(16)) if_a ();
    rc4_stream_core_if #(.W(8), .KEYLEN_MAX(3))  if_b ();
    rc4_stream_core_if #(.W(4), .KEYLEN_MAX(16)) if_c ();

    rc4_stream_core #(.W(8), .KEYLEN_MAX(16)) dut_a (.clk(clk), .reset(rst_a), .bus(if_a.slave));
    rc4_stream_core #(.W(8), .KEYLEN_MAX(3))  dut_b (.clk(clk), .reset(rst_b), .bus(if_b.slave));
    rc4_stream_core #(.W(4), .KEYLEN_MAX(16)) dut_c (.clk(clk), .reset(rst_c), .bus(if_c.slave));

    assign if_a.key_wr    = key_wr & (sel == 0);
    assign if_a.key_addr  = key_addr;
    assign if_a.key_din   = key_din;
    assign if_a.key_len   = key_len;
    assign if_a.start     = start & (sel == 0);
    assign if_a.in_valid  = in_valid & (sel == 0);
    assign if_a.in_data   = in_data;
    assign if_a.out_ready = out_ready;

    assign if_b.key_wr    = key_wr & (sel == 1);
    assign if_b.key_addr  = key_addr[1:0];
    assign if_b.key_din   = key_din;
    assign if_b.key_len   = key_len[1:0];
    assign if_b.start     = start & (sel == 1);
    assign if_b.in_valid  = in_valid & (sel == 1);
    assign if_b.in_data   = in_data;
    assign if_b.out_ready = out_ready;

    assign if_c.key_wr    = key_wr & (sel == 2);
    assign if_c.key_addr  = key_addr;
    assign if_c.key_din   = key_din[3:0];
    assign if_c.key_len   = key_len;
    assign if_c.start     = start & (sel == 2);
    assign if_c.in_valid  = in_valid & (sel == 2);
    assign if_c.in_data   = in_data[3:0];
    assign if_c.out_ready = out_ready;

    // Route the selected core's outputs to common observation signals
    always_comb begin
        busy_m      = if_a.busy;
        ready_m     = if_a.ready;
        in_ready_m  = if_a.in_ready;
        out_valid_m = if_a.out_valid;
        out_data_m  = if_a.out_data;
        if (sel == 1) begin
            busy_m      = if_b.busy;
            ready_m     = if_b.ready;
            in_ready_m  = if_b.in_ready;
            out_valid_m = if_b.out_valid;
            out_data_m  = if_b.out_data;
        end else if (sel == 2) begin
            busy_m      = if_c.busy;
            ready_m     = if_c.ready;
            in_ready_m  = if_c.in_ready;
            out_valid_m = if_c.out_valid;
            out_data_m  = {4'h0, if_c.out_data};
        end
    end

    typedef struct {
        int               sel;
        logic [0:3][7:0]  key;
        int               nkey;
        logic [4:0]       klen;
        int               n;
        logic [0:9][7:0]  din;
        logic [0:9][7:0]  dexp;
        int               stall;
        bit               ksa_wr;
    } vec_t;

    vec_t vt [5];

    // W=4 reference model state
    logic [3:0] m_s   [16];
    logic [3:0] m_key [4];
    logic [3:0] m_din [40];
    logic [3:0] m_exp [40];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model4();
        logic [3:0] i, j, t, tmp;
        for (int a = 0; a < 16; a++) m_s[a] = 4'(a);
        j = 4'd0;
        for (int a = 0; a < 16; a++) begin
            j = j + m_s[a] + m_key[a % 4];
            tmp = m_s[a]; m_s[a] = m_s[j]; m_s[j] = tmp;
        end
        i = 4'd0;
        j = 4'd0;
        for (int k = 0; k < 40; k++) begin
            i = i + 4'd1;
            j = j + m_s[i];
            tmp = m_s[i]; m_s[i] = m_s[j]; m_s[j] = tmp;
            t = m_s[i] + m_s[j];
            m_exp[k] = m_din[k] ^ m_s[t];
        end
    endtask

    // Load key (last word written in the same cycle as start), then count busy cycles
    task automatic start_core(input int s, input logic [0:3][7:0] k, input int nk,
                              input logic [4:0] kl, input bit kw, input int abort_at,
                              output int cnt);
        sel = s;
        @(posedge clk); #1;
        for (int idx = 0; idx < nk - 1; idx++) begin
            key_wr = 1'b1; key_addr = 4'(idx); key_din = k[idx];
            @(posedge clk); #1;
        end
        key_wr = 1'b1; key_addr = 4'(nk - 1); key_din = k[nk - 1];
        start = 1'b1; key_len = kl;
        @(posedge clk); #1;
        key_wr = 1'b0; start = 1'b0;
        cnt = 0;
        while (busy_m && cnt < 2000) begin
            if (abort_at >= 0 && cnt == abort_at) begin
                rst_one = 1'b1;
                @(posedge clk); #1;
                rst_one = 1'b0;
                return;
            end
            key_wr = kw && (cnt == 300);
            key_addr = 4'd0; key_din = 8'hFF;
            cnt++;
            @(posedge clk); #1;
        end
        key_wr = 1'b0;
    endtask

    task automatic stream(input int n, input logic [0:9][7:0] din,
                          input logic [0:9][7:0] dexp, input int stall);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1; in_data = din[k]; out_ready = 1'b1;
            #1;
            chk("in_ready", 32'(in_ready_m), 32'd1);
            @(posedge clk); #1;
            chk("out_word", {out_valid_m, out_data_m}, {1'b1, dexp[k]});
            if (k == stall) begin
                out_ready = 1'b0;
                in_valid = (k + 1 < n);
                if (k + 1 < n) in_data = din[k + 1];
                for (int c = 0; c < 5; c++) begin
                    #1;
                    chk("stall_hold", {in_ready_m, out_valid_m, out_data_m}, {1'b0, 1'b1, dexp[k]});
                    @(posedge clk); #1;
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("drain", 32'(out_valid_m), 32'd0);
    endtask

    initial begin
        int cnt;
        int exp_busy;

        vt[0] = '{sel: 0, key: {8'h4B, 8'h65, 8'h79, 8'h00}, nkey: 3, klen: 5'd3, n: 9,
                  din:  {8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74, 8'h00},
                  dexp: {8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3, 8'h00},
                  stall: -1, ksa_wr: 1'b0};
        vt[1] = '{sel: 0, key: {8'h57, 8'h69, 8'h6B, 8'h69}, nkey: 4, klen: 5'd4, n: 5,
                  din:  {8'h70, 8'h65, 8'h64, 8'h69, 8'h61, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  dexp: {8'h10, 8'h21, 8'hBF, 8'h04, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  stall: -1, ksa_wr: 1'b0};
        vt[2] = '{sel: 0, key: {8'h57, 8'h69, 8'h6B, 8'h69}, nkey: 4, klen: 5'd4, n: 5,
                  din:  {8'h10, 8'h21, 8'hBF, 8'h04, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  dexp: {8'h70, 8'h65, 8'h64, 8'h69, 8'h61, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  stall: -1, ksa_wr: 1'b0};
        vt[3] = vt[0];
        vt[3].stall = 3;
        vt[4] = vt[0];
        vt[4].sel = 1;
        vt[4].klen = 5'd0;
        vt[4].ksa_wr = 1'b1;

        // Reset state of every core
        repeat (3) @(posedge clk);
        #1;
        rst_g = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("reset_state", {busy_m, ready_m, in_ready_m, out_valid_m, out_data_m}, 32'd0);
        end

        // Table-driven W=8 vectors
        for (int v = 0; v < 5; v++) begin
            exp_busy = (vt[v].sel == 2) ? 32 : 512;
            start_core(vt[v].sel, vt[v].key, vt[v].nkey, vt[v].klen, vt[v].ksa_wr, -1, cnt);
            chk("busy_cycles", 32'(cnt), 32'(exp_busy));
            chk("ready_after_ksa", {ready_m, out_valid_m}, {1'b1, 1'b0});
            stream(vt[v].n, vt[v].din, vt[v].dexp, vt[v].stall);
        end

        // W=4: reset 10 cycles into KSA, then a clean run against the model
        m_key[0] = 4'd7; m_key[1] = 4'd14; m_key[2] = 4'd11; m_key[3] = 4'd6;
        start_core(2, {8'h07, 8'h0E, 8'h0B, 8'h06}, 4, 5'd4, 1'b0, 26, cnt);
        chk("abort_busy_drop", {busy_m, ready_m, in_ready_m, out_valid_m}, 32'd0);
        start_core(2, {8'h07, 8'h0E, 8'h0B, 8'h06}, 4, 5'd4, 1'b0, -1, cnt);
        chk("w4_busy_cycles", 32'(cnt), 32'd32);
        chk("w4_ready", {ready_m, out_valid_m}, {1'b1, 1'b0});

        for (int k = 0; k < 40; k++) m_din[k] = 4'((k * 5 + 3) % 16);
        model4();
        for (int k = 0; k < 40; k++) begin
            in_valid = 1'b1; in_data = {4'h0, m_din[k]}; out_ready = 1'b1;
            @(posedge clk); #1;
            chk("w4_word", {out_valid_m, out_data_m}, {1'b1, 4'h0, m_exp[k]});
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("w4_drain", 32'(out_valid_m), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
